// File: rtl/or16_arbiter.sv
// Round-robin front end sharing one combinational Or16 between NREQ requesters.
// Optional per-requester grant counters are enabled by defining OR16_ARB_STATS_EN.
module or16_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*WIDTH-1:0] REQ_A,
  input  logic [NREQ*WIDTH-1:0] REQ_B,
  output logic [WIDTH-1:0]      OR_A,
  output logic [WIDTH-1:0]      OR_B,
  input  logic [WIDTH-1:0]      OR_OUT,
  output logic                  RSP_VALID,
  output logic [IDW-1:0]        RSP_ID,
  output logic [WIDTH-1:0]      RSP_DATA,
`ifdef OR16_ARB_STATS_EN
  output logic [NREQ*16-1:0]    GRANT_CNT,
`endif
  input  logic                  RSP_READY
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [WIDTH-1:0] or_a_q, or_b_q, rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;

  logic             hi_found, lo_found, gnt_any;
  logic [IDW-1:0]   hi_idx, lo_idx, gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Search above rr_ptr first, then wrap to the indices at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ_VALID[i]) begin
        if (IDW'(i) > rr_ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i);
        end
      end
    end
    gnt_any = hi_found | lo_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt_oh  = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == StIdle) && gnt_any && (IDW'(i) == gnt_idx)) begin
        gnt_oh[i] = 1'b1;
        sel_a     = REQ_A[i*WIDTH +: WIDTH];
        sel_b     = REQ_B[i*WIDTH +: WIDTH];
      end
    end
  end

  assign REQ_READY = gnt_oh;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      rr_ptr_q    <= IDW'(NREQ - 1);
      or_a_q      <= '0;
      or_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            or_a_q   <= sel_a;
            or_b_q   <= sel_b;
            rsp_id_q <= gnt_idx;
            rr_ptr_q <= gnt_idx;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_data_q  <= OR_OUT;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign OR_A      = or_a_q;
  assign OR_B      = or_b_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_VALID = rsp_valid_q;

`ifdef OR16_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_oh[i] && REQ_VALID[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    GRANT_CNT = '0;
    for (int i = 0; i < NREQ; i++) GRANT_CNT[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule
